// File: rtl/bus_slave_mem.sv
// -----------------------------------------------------------------------------
// bus_slave_mem
//   Word-addressed memory slave on the system bus. Decodes the master's packed
//   HADDR, inserts WAIT_STATES wait cycles, commits writes into internal RAM
//   and returns read data with HREADY/HRESP. Several instances, told apart by
//   SLAVE_ID, share one bus behind the arbiter.
//
// Ports
//   CLK         in   1   bus clock, all logic on the rising edge
//   RST_N       in   1   asynchronous active-low reset
//   HADDR       in  16   [15] active, [14:13] slave select, [12] write, [11:0] byte address
//   HWDATA      in  32   write data, sampled at the end of the WR_CAP cycle
//   HRDATA      out 32   read data, valid while HREADY=1 in the read data phase
//   HREADY      out  1   transfer-complete strobe; 0 while idle or waiting
//   HRESP       out  2   00 OKAY, 01 ERROR, 11 SPLIT (10 RETRY is never issued)
//   SPLIT_DONE  out  1   one-cycle pulse: split data ready, re-grant the master
//   BUSY        out  1   high in every state except IDLE
//
// Build option
//   SPLIT_RESP_EN  when defined, reads with WAIT_STATES >= SPLIT_THRESHOLD are
//                  answered with SPLIT, and the slave raises SPLIT_DONE once the
//                  data is ready. When undefined, SPLIT_DONE is tied low and
//                  HRESP never equals SPLIT.
// -----------------------------------------------------------------------------
module bus_slave_mem #(
    parameter logic [1:0] SLAVE_ID        = 2'd0,
    parameter int         MEM_DEPTH       = 256,
    parameter int         WAIT_STATES     = 2,
    parameter int         RD_HOLD         = 2,
    parameter int         SPLIT_THRESHOLD = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP,
    output logic        SPLIT_DONE,
    output logic        BUSY
);

    localparam int         AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic [3:0] RD_LOAD    = 4'(RD_HOLD);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WR_ACK,
        ST_WR_CAP,
        ST_RD_DATA,
        ST_ERR,
        ST_SPLIT_RSP,
        ST_SPLIT_WAIT
    } state_t;

    state_t      state;
    logic [9:0]  idx;        // latched word index
    logic        wr;         // latched write flag
    logic [3:0]  cnt;        // shared wait / hold counter
    logic [31:0] mem [MEM_DEPTH];

    // Address decode of the live bus; only looked at while IDLE.
    logic          sel;
    logic          idx_bad;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] bus_addr;
    logic          unused_addr_bits;

    assign sel       = HADDR[15] && (HADDR[14:13] == SLAVE_ID);
    assign idx_bad   = {1'b0, HADDR[11:2]} >= 11'(MEM_DEPTH);
    assign mem_addr  = idx[AW-1:0];
    assign bus_addr  = HADDR[AW+1:2];
    // Byte offset bits are ignored: every access is word-aligned.
    assign unused_addr_bits = ^HADDR[1:0];

`ifdef SPLIT_RESP_EN
    localparam logic [1:0] RESP_SPLIT  = 2'b11;
    localparam bit         SPLIT_READS = (WAIT_STATES >= SPLIT_THRESHOLD);
    logic split_done_q;
    assign SPLIT_DONE = split_done_q;
`else
    localparam bit unused_split_threshold = (SPLIT_THRESHOLD > 0);
    assign SPLIT_DONE = 1'b0;
`endif

    // Control FSM. Every output is a register updated together with the state,
    // so each branch sets the outputs for the state it is moving into.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // flop samples the pre-edge values regardless of statement order.
            state  <= ST_IDLE;
            idx    <= '0;
            wr     <= 1'b0;
            cnt    <= '0;
            HRDATA <= '0;
            HREADY <= 1'b0;
            HRESP  <= RESP_OKAY;
            BUSY   <= 1'b0;
`ifdef SPLIT_RESP_EN
            split_done_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel) begin
                        idx  <= HADDR[11:2];
                        wr   <= HADDR[12];
                        cnt  <= WAIT_LOAD;
                        BUSY <= 1'b1;
                        if (idx_bad) begin
                            state  <= ST_ERR;
                            HREADY <= 1'b1;
                            HRESP  <= RESP_ERROR;
                            HRDATA <= '0;
                        end
`ifdef SPLIT_RESP_EN
                        else if (!HADDR[12] && SPLIT_READS) begin
                            state <= ST_SPLIT_RSP;
                            HRESP <= RESP_SPLIT;
                        end
`endif
                        else if (WAIT_STATES == 0) begin
                            // No wait phase: first HREADY one cycle after decode.
                            HREADY <= 1'b1;
                            if (HADDR[12]) begin
                                state <= ST_WR_ACK;
                            end else begin
                                state  <= ST_RD_DATA;
                                HRDATA <= mem[bus_addr];
                                cnt    <= RD_LOAD;
                            end
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (cnt <= 4'd1) begin
                        HREADY <= 1'b1;
                        if (wr) begin
                            state <= ST_WR_ACK;
                        end else begin
                            state  <= ST_RD_DATA;
                            HRDATA <= mem[mem_addr];
                            cnt    <= RD_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_WR_ACK: begin
                    state <= ST_WR_CAP;
                end

                // The RAM write itself happens in the memory process below.
                ST_WR_CAP: begin
                    state  <= ST_IDLE;
                    HREADY <= 1'b0;
                    BUSY   <= 1'b0;
                end

                ST_RD_DATA: begin
                    if (cnt <= 4'd1) begin
                        state  <= ST_IDLE;
                        HREADY <= 1'b0;
                        HRDATA <= '0;
                        BUSY   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_ERR: begin
                    state  <= ST_IDLE;
                    HREADY <= 1'b0;
                    HRESP  <= RESP_OKAY;
                    BUSY   <= 1'b0;
                end

`ifdef SPLIT_RESP_EN
                ST_SPLIT_RSP: begin
                    state <= ST_SPLIT_WAIT;
                    HRESP <= RESP_OKAY;
                    cnt   <= WAIT_LOAD;
                end

                // WAIT_STATES quiet cycles, then one cycle with SPLIT_DONE high,
                // then the normal read data phase.
                ST_SPLIT_WAIT: begin
                    if (cnt == 4'd0) begin
                        split_done_q <= 1'b0;
                        state        <= ST_RD_DATA;
                        HREADY       <= 1'b1;
                        HRDATA       <= mem[mem_addr];
                        cnt          <= RD_LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            split_done_q <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state  <= ST_IDLE;
                    HREADY <= 1'b0;
                    HRESP  <= RESP_OKAY;
                    HRDATA <= '0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the RAM is deliberately left out of reset; contents survive RST_N and
    // a reset before the WR_CAP edge leaves state != WR_CAP, so no write commits.
    always_ff @(posedge CLK) begin
        if (state == ST_WR_CAP) begin
            mem[mem_addr] <= HWDATA;
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_bus_slave_mem
//   Self-checking bench for bus_slave_mem. Two instances share HADDR/HWDATA:
//   u_dut1 (SLAVE_ID=1, WAIT_STATES=2, or 4 when SPLIT_RESP_EN is defined) and
//   u_dut0 (SLAVE_ID=3, WAIT_STATES=0). Expected per-cycle output traces are
//   built from the transfer rules with plain queues and a word array model.
// -----------------------------------------------------------------------------
module tb_bus_slave_mem;

    localparam int DEPTH = 256;
    localparam int RDH   = 2;
`ifdef SPLIT_RESP_EN
    localparam int WS1    = 4;
    localparam bit SPLIT1 = 1'b1;
`else
    localparam int WS1    = 2;
    localparam bit SPLIT1 = 1'b0;
`endif
    localparam logic [1:0] SID1 = 2'd1;
    localparam logic [1:0] SID0 = 2'd3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] haddr = '0;
    logic [31:0] hwdata = '0;

    logic [31:0] hrdata1, hrdata0;
    logic        hready1, hready0;
    logic [1:0]  hresp1, hresp0;
    logic        split_done1, split_done0;
    logic        busy1, busy0;

    bus_slave_mem #(.SLAVE_ID(SID1), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1),
                    .RD_HOLD(RDH), .SPLIT_THRESHOLD(4)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1),
        .SPLIT_DONE(split_done1), .BUSY(busy1)
    );

    bus_slave_mem #(.SLAVE_ID(SID0), .MEM_DEPTH(DEPTH), .WAIT_STATES(0),
                    .RD_HOLD(RDH), .SPLIT_THRESHOLD(4)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0),
        .SPLIT_DONE(split_done0), .BUSY(busy0)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference memory per instance; only written entries are ever read back.
    logic [31:0] mmem   [2][DEPTH];
    bit          mvalid [2][DEPTH];

    // Observation vector: {BUSY, HREADY, HRESP, SPLIT_DONE, HRDATA}.
    function automatic logic [36:0] obs(input int d);
        if (d == 1) return {busy1, hready1, hresp1, split_done1, hrdata1};
        return {busy0, hready0, hresp0, split_done0, hrdata0};
    endfunction

    function automatic logic [36:0] rec(input bit busy, input bit rdy, input logic [1:0] resp,
                                        input bit sd, input logic [31:0] data);
        return {busy, rdy, resp, sd, data};
    endfunction

    task automatic check(input string tag, input logic [36:0] o, input logic [36:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Bus noise during a transfer: only targets the busy instance, slave 0 or
    // slave 2, so the other instance must stay idle.
    function automatic logic [15:0] junk_addr(input int d);
        logic [1:0] s;
        int         pick;
        pick = $urandom_range(0, 2);
        s = (pick == 0) ? ((d == 1) ? SID1 : SID0) : ((pick == 1) ? 2'd0 : 2'd2);
        return {1'($urandom), s, 1'($urandom), 10'($urandom), 2'($urandom)};
    endfunction

    // One full transfer on instance d, checked cycle by cycle from decode.
    task automatic run_txn(input int d, input bit wr, input int idx,
                           input logic [31:0] wdata, input string tag);
        logic [36:0] exp_q[$];
        int          ws;
        bit          split;
        logic [1:0]  sid;
        int          wr_cycle;
        ws       = (d == 1) ? WS1 : 0;
        split    = (d == 1) && SPLIT1;
        sid      = (d == 1) ? SID1 : SID0;
        wr_cycle = -1;

        if (idx >= DEPTH) begin
            exp_q.push_back(rec(1, 1, 2'b01, 0, '0));
        end else if (!wr && split) begin
            exp_q.push_back(rec(1, 0, 2'b11, 0, '0));
            repeat (ws) exp_q.push_back(rec(1, 0, 2'b00, 0, '0));
            exp_q.push_back(rec(1, 0, 2'b00, 1, '0));
            repeat (RDH) exp_q.push_back(rec(1, 1, 2'b00, 0, mmem[d][idx]));
        end else begin
            repeat (ws) exp_q.push_back(rec(1, 0, 2'b00, 0, '0));
            if (wr) begin
                repeat (2) exp_q.push_back(rec(1, 1, 2'b00, 0, '0));
                wr_cycle = ws + 1;
            end else begin
                repeat (RDH) exp_q.push_back(rec(1, 1, 2'b00, 0, mmem[d][idx]));
            end
        end

        haddr  = {1'b1, sid, wr, 10'(idx), 2'($urandom)};
        hwdata = $urandom;
        @(posedge CLK); #1;
        foreach (exp_q[k]) begin
            check($sformatf("%s.c%0d", tag, k), obs(d), exp_q[k]);
            check($sformatf("%s.other%0d", tag, k), obs(1 - d), '0);
            haddr  = junk_addr(d);
            hwdata = (k == wr_cycle) ? wdata : $urandom;
            @(posedge CLK); #1;
        end
        check($sformatf("%s.idle", tag), obs(d), '0);
        check($sformatf("%s.other_idle", tag), obs(1 - d), '0);
        haddr = '0;
        if (wr_cycle >= 0) begin
            mmem[d][idx]   = wdata;
            mvalid[d][idx] = 1'b1;
        end
    endtask

    // Start a transfer on u_dut1, assert reset k cycles after decode.
    task automatic reset_at(input logic [15:0] a, input int k, input logic [36:0] pre_exp,
                            input logic [31:0] wd, input string tag);
        haddr = a;
        @(posedge CLK); #1;
        haddr = '0;
        repeat (k) begin
            @(posedge CLK); #1;
        end
        check({tag, ".pre"}, obs(1), pre_exp);
        hwdata = wd;
        RST_N  = 1'b0;
        #1;
        check({tag, ".async"}, obs(1), '0);
        check({tag, ".async_other"}, obs(0), '0);
        @(posedge CLK); #1;
        check({tag, ".held"}, obs(1), '0);
        RST_N = 1'b1;
        #1;
        check({tag, ".released"}, obs(1), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          idx;
        int          r;
        bit          wr;
        logic [31:0] wd;

        // Reset state.
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset", obs(1), '0);
        check("reset_other", obs(0), '0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("after_release", obs(1), '0);

        // Directed write and read-back on the SLAVE_ID=1 instance.
        run_txn(1, 1'b1, 4, 32'hDEADBEEF, "wr_b010");
        run_txn(1, 1'b0, 4, '0, "rd_a010");

        // Slave-select miss and inactive transfer: nobody responds.
        haddr = 16'hD010;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check($sformatf("miss%0d", i), obs(1), '0);
            check($sformatf("miss_other%0d", i), obs(0), '0);
        end
        haddr = 16'h3010;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            check($sformatf("inactive%0d", i), obs(1), '0);
        end
        haddr = '0;
        run_txn(1, 1'b0, 4, '0, "rd_after_miss");

        // Decode errors (idx 1023 and first out-of-range word), no RAM write.
        run_txn(1, 1'b1, 1023, 32'h0BAD0BAD, "derr_1023");
        run_txn(1, 1'b1, DEPTH, 32'h0BAD0BAD, "derr_256");
        run_txn(1, 1'b0, 4, '0, "rd_after_derr");
        run_txn(0, 1'b1, 1023, 32'h0BAD0BAD, "derr_ws0");

        // Zero wait states and the last valid word.
        run_txn(0, 1'b1, 0, 32'hA5A5_0001, "wr_ws0");
        run_txn(0, 1'b0, 0, '0, "rd_ws0");
        run_txn(1, 1'b1, DEPTH - 1, 32'h1234_ABCD, "wr_last");
        run_txn(1, 1'b0, DEPTH - 1, '0, "rd_last");

        // Reset mid-transfer: mid-WAIT, mid-read data, and just before commit.
        reset_at(16'hB010, 0, rec(1, 0, 2'b00, 0, '0), 32'h1111_1111, "rst_wait");
        reset_at(16'hA010, SPLIT1 ? WS1 + 2 : WS1, rec(1, 1, 2'b00, 0, 32'hDEADBEEF),
                 32'h2222_2222, "rst_rd");
        reset_at(16'hB010, WS1 + 1, rec(1, 1, 2'b00, 0, '0), 32'h1234_5678, "rst_wrcap");
        run_txn(1, 1'b0, 4, '0, "rd_after_abort");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            d  = $urandom_range(0, 1);
            r  = $urandom_range(0, 9);
            wd = $urandom;
            if (r == 0) idx = $urandom_range(DEPTH, 1023);
            else if (r < 6) idx = $urandom_range(0, 7);
            else idx = $urandom_range(0, DEPTH - 1);
            wr = 1'($urandom_range(0, 1));
            if (idx < DEPTH) begin
                if (!mvalid[d][idx]) wr = 1'b1;
            end
            run_txn(d, wr, idx, wd, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
- Word-addressed memory slave on the system bus; the responder end for the bus master.
- Decodes the master's packed HADDR (active flag, slave select, write flag, byte address) and inserts programmable wait states.
- Completes writes into internal RAM and returns read data with HREADY/HRESP.
- Several instances, distinguished by SLAVE_ID, share the bus behind the arbiter.

Parameters:
- SLAVE_ID, 2'd0, value matched against HADDR[14:13].
- MEM_DEPTH, 256, RAM size in 32-bit words, valid range 1..1024.
- WAIT_STATES, 2, HREADY-low cycles inserted after address decode, valid range 0..15.
- RD_HOLD, 2, cycles HRDATA/HREADY are held valid in the read data phase, valid range 1..15.
- SPLIT_THRESHOLD, 4, minimum WAIT_STATES at which reads are split (only with SPLIT_RESP_EN).

Ports:
- CLK  in  1  bus clock, all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- HADDR  in  16  [15]=active transfer (1=START), [14:13]=slave select, [12]=write(1)/read(0), [11:0]=byte address.
- HWDATA  in  32  write data from master.
- HRDATA  out  32  read data.
- HREADY  out  1  transfer-complete strobe; 0 while idle or waiting.
- HRESP  out  2  00 OKAY, 01 ERROR, 10 RETRY (never issued), 11 SPLIT.
- SPLIT_DONE  out  1  one-cycle pulse to the arbiter: split data ready, re-grant the master.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N=0, async): state=IDLE; HRDATA=0, HREADY=0, HRESP=OKAY, SPLIT_DONE=0, BUSY=0. RAM contents are not cleared.
- Reset mid-transfer aborts immediately. A write in progress does not commit.
- All outputs are registered.
- States: IDLE, WAIT, WR_ACK, WR_CAP, RD_DATA, ERR, SPLIT_RSP, SPLIT_WAIT.
- IDLE: selected when HADDR[15]=1 and HADDR[14:13]=SLAVE_ID at a rising edge. On selection, latch idx=HADDR[11:2], wr=HADDR[12], load wait counter=WAIT_STATES.
  - HADDR[1:0] is ignored; accesses are always word-aligned.
  - Unselected or inactive HADDR: remain IDLE.
- Decode error: if idx>=MEM_DEPTH, go to ERR in place of WAIT.
- WAIT: HREADY=0, HRESP=OKAY. Counter decrements each cycle. At zero: wr=1 -> WR_ACK, wr=0 -> RD_DATA.
  - WAIT_STATES=0 skips WAIT entirely, giving first HREADY one cycle after decode.
- Write path:
  - WR_ACK: HREADY=1, HRESP=OKAY for one cycle.
  - WR_CAP: HREADY=1. At the end of this cycle sample HWDATA, write mem[idx], go to IDLE.
  - Write latency from decode edge to commit edge = WAIT_STATES+2 cycles.
- RD_DATA: HRDATA=mem[idx], HREADY=1, HRESP=OKAY for RD_HOLD cycles, then HRDATA=0, HREADY=0, go to IDLE.
  - Read-after-write to the same idx returns the new data.
- ERR: HREADY=1, HRESP=ERROR, HRDATA=0 for one cycle, then IDLE. No RAM write occurs.
- HADDR activity during a transfer is ignored; there is no pipelining and at most one outstanding transfer.
- BUSY=1 in every state except IDLE.

Optional Feature:
- SPLIT_RESP_EN defined: a read with WAIT_STATES>=SPLIT_THRESHOLD enters SPLIT_RSP in place of WAIT.
  - SPLIT_RSP: HRESP=SPLIT, HREADY=0 for one cycle.
  - SPLIT_WAIT: count WAIT_STATES cycles with HRESP=OKAY, HREADY=0.
  - On reaching zero: pulse SPLIT_DONE for one cycle, then RD_DATA as normal.
  - New HADDR selections while split are ignored.
- SPLIT_RESP_EN undefined: SPLIT_RSP/SPLIT_WAIT are absent, SPLIT_DONE is tied 0, and HRESP never equals SPLIT.

Test Plan:
- Reset: RST_N low mid-WAIT -> all outputs zero in the same cycle (async); after release, state IDLE and BUSY=0.
- Write: SLAVE_ID=1, WAIT_STATES=2, HADDR=16'hB010, HWDATA=32'hDEADBEEF in the cycle after the first HREADY -> HREADY low 2 cycles, high 2 cycles, mem[4]=32'hDEADBEEF.
- Read-back: HADDR=16'hA010 -> after 2 wait cycles HRDATA=32'hDEADBEEF with HREADY=1 for RD_HOLD=2 cycles, then HRDATA=0.
- Slave-select miss: HADDR=16'hD010 on the SLAVE_ID=1 instance -> stays IDLE, HREADY=0, BUSY=0, RAM unchanged.
- Decode error: MEM_DEPTH=256, HADDR=16'hBFFC (idx 1023) -> one cycle HREADY=1, HRESP=01, no write; WAIT_STATES=0 variant shows HREADY one cycle after decode.
- Split (SPLIT_RESP_EN, WAIT_STATES=4): read HADDR=16'hA010 -> HRESP=11 for 1 cycle, 4 wait cycles, SPLIT_DONE pulse, then HRDATA=32'hDEADBEEF valid 2 cycles.
